lc3_decode: RTL and testbench

LC3_DECODE -- requirements
Module: lc3_decode

---
 rtl/lc3_decode.sv | 80 ++++++++
 tb/tb_lc3_decode.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage that registers the fetched instruction, its NPC,
// and the execute/writeback/memory control fields decoded from it.
module lc3_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] instr_dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        decode_valid,
    output logic        illegal_instr
);
    logic [3:0]  op;
    logic        is_add, is_and, is_not, is_br, is_jmp, is_ld, is_ldr, is_ldi;
    logic        is_lea, is_st, is_str, is_sti, use_off9;
    logic [15:0] ir_q, npc_q;
    logic [5:0]  e_q, e_d;
    logic [1:0]  w_q, w_d;
    logic        m_q, m_d, v_q, ill_q, ill_d;

    assign op       = instr_dout[15:12];
    assign is_add   = op == 4'h1;
    assign is_and   = op == 4'h5;
    assign is_not   = op == 4'h9;
    assign is_br    = op == 4'h0;
    assign is_jmp   = op == 4'hC;
    assign is_ld    = op == 4'h2;
    assign is_ldr   = op == 4'h6;
    assign is_ldi   = op == 4'hA;
    assign is_lea   = op == 4'hE;
    assign is_st    = op == 4'h3;
    assign is_str   = op == 4'h7;
    assign is_sti   = op == 4'hB;
    assign use_off9 = is_br | is_ld | is_ldi | is_st | is_sti | is_lea;

    // Unsupported opcodes match none of the terms below, so their controls fall to 0.
    always_comb begin
        e_d   = {is_not ? 2'b10 : is_and ? 2'b01 : 2'b00,
                 use_off9 ? 2'b01 : (is_ldr | is_str) ? 2'b10 : is_jmp ? 2'b11 : 2'b00,
                 use_off9,
                 (is_add | is_and) & ~instr_dout[5]};
        w_d   = is_lea ? 2'b01 : (is_ld | is_ldr | is_ldi) ? 2'b10 : 2'b00;
        m_d   = is_ldi | is_sti;
        ill_d = (op == 4'h4) | (op == 4'h8) | (op == 4'hD) | (op == 4'hF);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q  <= '0;
            npc_q <= '0;
            e_q   <= '0;
            w_q   <= '0;
            m_q   <= 1'b0;
            v_q   <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            v_q <= enable_decode;
            if (enable_decode) begin
                ir_q  <= instr_dout;
                npc_q <= npc_in;
                e_q   <= e_d;
                w_q   <= w_d;
                m_q   <= m_d;
                ill_q <= ill_d;
            end
        end
    end

    assign IR            = ir_q;
    assign npc_out       = npc_q;
    assign E_Control     = e_q;
    assign W_Control     = w_q;
    assign Mem_Control   = m_q;
    assign decode_valid  = v_q;
    assign illegal_instr = ill_q;
endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: directed scoreboard bench for the LC-3 decode stage.
module tb_lc3_decode;
    logic        clock = 1'b0, reset = 1'b1, enable_decode = 1'b0;
    logic [15:0] instr_dout = '0, npc_in = '0;
    logic [15:0] IR, npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control, decode_valid, illegal_instr;
    int          total = 0, bad = 0;

    typedef struct packed {
        logic [15:0] ir, npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m, v, ill;
    } exp_t;
    exp_t q[$];
    exp_t mdl = '0;

    lc3_decode dut (
        .clock(clock), .reset(reset), .enable_decode(enable_decode),
        .instr_dout(instr_dout), .npc_in(npc_in), .IR(IR), .npc_out(npc_out),
        .E_Control(E_Control), .W_Control(W_Control), .Mem_Control(Mem_Control),
        .decode_valid(decode_valid), .illegal_instr(illegal_instr)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check();
        exp_t x;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            x = q.pop_front();
            cmp("IR", IR, x.ir);
            cmp("npc_out", npc_out, x.npc);
            cmp("E_Control", {10'd0, E_Control}, {10'd0, x.e});
            cmp("W_Control", {14'd0, W_Control}, {14'd0, x.w});
            cmp("Mem_Control", {15'd0, Mem_Control}, {15'd0, x.m});
            cmp("decode_valid", {15'd0, decode_valid}, {15'd0, x.v});
            cmp("illegal_instr", {15'd0, illegal_instr}, {15'd0, x.ill});
        end
    endtask

    task automatic zero_check();
        mdl = '0;
        q.push_back(mdl);
        check();
    endtask

    // Drives one cycle; on enable the model takes the directed expected controls.
    task automatic step(input logic en, input logic [15:0] ins, input logic [15:0] npc,
                        input logic [5:0] e, input logic [1:0] w, input logic m, input logic ill);
        enable_decode = en;
        instr_dout    = ins;
        npc_in        = npc;
        if (en) begin
            mdl.ir  = ins;
            mdl.npc = npc;
            mdl.e   = e;
            mdl.w   = w;
            mdl.m   = m;
            mdl.ill = ill;
        end
        mdl.v = en;
        q.push_back(mdl);
        @(posedge clock);
        #1;
        check();
    endtask

    initial begin
        #2;
        zero_check();
        enable_decode = 1'b1;
        instr_dout    = 16'h1283;
        npc_in        = 16'h3001;
        @(posedge clock);
        #1;
        zero_check();
        reset = 1'b0;
        step(1, 16'h1283, 16'h3001, 6'b000001, 2'b00, 0, 0);
        step(1, 16'h12A5, 16'h3002, 6'b000000, 2'b00, 0, 0);
        step(1, 16'hA005, 16'h3003, 6'b000110, 2'b10, 1, 0);
        step(1, 16'hE1FF, 16'h3004, 6'b000110, 2'b01, 0, 0);
        step(1, 16'h6285, 16'h3005, 6'b001000, 2'b10, 0, 0);
        step(1, 16'hC080, 16'h3006, 6'b001100, 2'b00, 0, 0);
        step(1, 16'h967F, 16'h3007, 6'b100000, 2'b00, 0, 0);
        step(1, 16'h5060, 16'h3008, 6'b010000, 2'b00, 0, 0);
        step(1, 16'h5042, 16'h3009, 6'b010001, 2'b00, 0, 0);
        step(1, 16'h0E05, 16'h300A, 6'b000110, 2'b00, 0, 0);
        step(1, 16'h3005, 16'h300B, 6'b000110, 2'b00, 0, 0);
        step(1, 16'h7285, 16'h300C, 6'b001000, 2'b00, 0, 0);
        step(1, 16'hB005, 16'h300D, 6'b000110, 2'b00, 1, 0);
        step(1, 16'h2005, 16'h300E, 6'b000110, 2'b10, 0, 0);
        step(1, 16'h1283, 16'h4001, 6'b000001, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 16'h5000, 16'h9999, 6'b010001, 2'b00, 0, 0);
        step(1, 16'hF025, 16'h4002, 6'b000000, 2'b00, 0, 1);
        step(0, 16'h1283, 16'h4003, 6'b000001, 2'b00, 0, 0);
        step(1, 16'h1283, 16'h4004, 6'b000001, 2'b00, 0, 0);
        step(1, 16'h4000, 16'h4005, 6'b000000, 2'b00, 0, 1);
        step(1, 16'h8000, 16'h4006, 6'b000000, 2'b00, 0, 1);
        step(1, 16'hD000, 16'h4007, 6'b000000, 2'b00, 0, 1);
        step(1, 16'hA005, 16'h4008, 6'b000110, 2'b10, 1, 0);
        enable_decode = 1'b1;
        instr_dout    = 16'h5000;
        npc_in        = 16'h7777;
        #1 reset = 1'b1;
        #1;
        zero_check();
        @(posedge clock);
        #1;
        zero_check();
        reset = 1'b0;
        step(1, 16'h2005, 16'h5001, 6'b000110, 2'b10, 0, 0);
        step(0, 16'h0000, 16'h0000, 6'b000000, 2'b00, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
